// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller takes the master view; the datapath or a bench takes the slave view.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       memwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct3, zero, mem_ready,
        output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               immsrc, alusrca, alusrcb, aluop, resultsrc, retire, illegal, state
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               immsrc, alusrca, alusrcb, aluop, resultsrc, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of a multicycle RV32 subset core: fetch, decode, memory, ALU, branch, jal.
// Outputs are Moore-style per state except the ready-qualified strobes and branch pcwrite.
//
// state    | meaning
// ---------+--------------------------------------------------------
// FETCH    | read instruction at PC, PC <- PC+4 on mem_ready
// DECODE   | register read, ALU computes branch target
// MEMADR   | ALU computes rs1 + imm for load/store
// MEMREAD  | load request pending at ALU-out address
// MEMWB    | write load data to rd
// MEMWRITE | store request pending, retires on mem_ready
// EXECR    | ALU rs1 op rs2
// EXECI    | ALU rs1 op imm
// ALUWB    | write ALU-out register to rd
// BRANCH   | compare rs1/rs2, conditionally take target
// JAL      | PC <- target, ALU computes old PC + 4
// HALT     | unsupported opcode, parked until reset
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     state_q, state_d;
    logic       illegal_q;

    logic       mem_req_c, memwrite_c, adrsrc_c, irwrite_c, pcwrite_c, regwrite_c, retire_c;
    logic [1:0] immsrc_c, alusrca_c, alusrcb_c, aluop_c, resultsrc_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        immsrc_c = 2'b00;
        case (bus.op)
            OP_STORE:  immsrc_c = 2'b01;
            OP_BRANCH: immsrc_c = 2'b10;
            OP_JAL:    immsrc_c = 2'b11;
            default:   immsrc_c = 2'b00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        memwrite_c  = 1'b0;
        adrsrc_c    = 1'b0;
        irwrite_c   = 1'b0;
        pcwrite_c   = 1'b0;
        regwrite_c  = 1'b0;
        retire_c    = 1'b0;
        alusrca_c   = 2'b00;
        alusrcb_c   = 2'b00;
        aluop_c     = 2'b00;
        resultsrc_c = 2'b00;

        case (state_q)
            FETCH: begin
                mem_req_c   = 1'b1;
                alusrcb_c   = 2'b10;
                resultsrc_c = 2'b10;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                alusrca_c = 2'b01;
                alusrcb_c = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = HALT;
                endcase
            end
            MEMADR: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                state_d   = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adrsrc_c  = 1'b1;
                if (bus.mem_ready)
                    state_d = MEMWB;
            end
            MEMWB: begin
                resultsrc_c = 2'b01;
                regwrite_c  = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                adrsrc_c   = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECR: begin
                alusrca_c = 2'b10;
                aluop_c   = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                aluop_c   = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca_c = 2'b10;
                aluop_c   = 2'b01;
                // only beq/bne are supported; funct3[0] inverts the zero test
                pcwrite_c = (bus.funct3[2:1] == 2'b00) & (bus.zero ^ bus.funct3[0]);
                retire_c  = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alusrca_c = 2'b01;
                alusrcb_c = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = ALUWB;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset gates every output combinationally so an in-flight request dies at once.
    assign bus.mem_req   = ~rst & mem_req_c;
    assign bus.memwrite  = ~rst & memwrite_c;
    assign bus.adrsrc    = ~rst & adrsrc_c;
    assign bus.irwrite   = ~rst & irwrite_c;
    assign bus.pcwrite   = ~rst & pcwrite_c;
    assign bus.regwrite  = ~rst & regwrite_c;
    assign bus.retire    = ~rst & retire_c;
    assign bus.immsrc    = rst ? 2'b00 : immsrc_c;
    assign bus.alusrca   = rst ? 2'b00 : alusrca_c;
    assign bus.alusrcb   = rst ? 2'b00 : alusrcb_c;
    assign bus.aluop     = rst ? 2'b00 : aluop_c;
    assign bus.resultsrc = rst ? 2'b00 : resultsrc_c;
    assign bus.illegal   = ~rst & illegal_q;
    assign bus.state     = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued as stimulus
// is applied and compared against the controller outputs at the falling edge.
module tb_multicycle_ctrl;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_HALT = 4'd11;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011,
                           OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic [1:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] resultsrc;
        logic       retire;
        logic       illegal;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    out_t  exp_q[$];
    string tag_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given state, taken from the per-state output table.
    function automatic out_t spec_out(input logic [3:0] st, input logic r, input logic [6:0] op,
                                      input logic [2:0] f3, input logic z, input logic rdy);
        out_t o;
        o = '0;
        if (r) return o;
        o.state = st;
        case (op)
            OP_STORE:  o.immsrc = 2'b01;
            OP_BRANCH: o.immsrc = 2'b10;
            OP_JAL:    o.immsrc = 2'b11;
            default:   o.immsrc = 2'b00;
        endcase
        case (st)
            S_FETCH: begin
                o.mem_req = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                o.irwrite = rdy; o.pcwrite = rdy;
            end
            S_DECODE:   begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
            S_MEMADR:   begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
            S_MEMREAD:  begin o.mem_req = 1; o.adrsrc = 1; end
            S_MEMWB:    begin o.resultsrc = 2'b01; o.regwrite = 1; o.retire = 1; end
            S_MEMWRITE: begin o.mem_req = 1; o.memwrite = 1; o.adrsrc = 1; o.retire = rdy; end
            S_EXECR:    begin o.alusrca = 2'b10; o.aluop = 2'b10; end
            S_EXECI:    begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.aluop = 2'b10; end
            S_ALUWB:    begin o.regwrite = 1; o.retire = 1; end
            S_BRANCH: begin
                o.alusrca = 2'b10; o.aluop = 2'b01; o.retire = 1;
                if (f3 == 3'b000)      o.pcwrite = z;
                else if (f3 == 3'b001) o.pcwrite = ~z;
                else                   o.pcwrite = 0;
            end
            S_JAL:  begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1; end
            S_HALT: o.illegal = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // One clock cycle: queue the expectation for the current inputs, compare at the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] st);
        out_t e, obs;
        string t;
        exp_q.push_back(spec_out(st, rst, bus.op, bus.funct3, bus.zero, bus.mem_ready));
        tag_q.push_back(tag);
        @(negedge clk);
        obs = '{state: bus.state, mem_req: bus.mem_req, memwrite: bus.memwrite,
                adrsrc: bus.adrsrc, irwrite: bus.irwrite, pcwrite: bus.pcwrite,
                regwrite: bus.regwrite, immsrc: bus.immsrc, alusrca: bus.alusrca,
                alusrcb: bus.alusrcb, aluop: bus.aluop, resultsrc: bus.resultsrc,
                retire: bus.retire, illegal: bus.illegal};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.op = OP_JAL;
        bus.funct3 = 3'b000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        // reset: everything forced low, even immsrc with a jal opcode present
        step("reset0", S_FETCH);
        step("reset1", S_FETCH);
        rst = 1'b0;

        // R-type, memory ready immediately
        bus.op = OP_RTYPE;
        step("r_fetch", S_FETCH);
        step("r_decode", S_DECODE);
        step("r_exec", S_EXECR);
        step("r_aluwb", S_ALUWB);

        // lw with three wait cycles in fetch and in memread
        bus.op = OP_LOAD;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", S_FETCH);
        bus.mem_ready = 1'b1;
        step("lw_fetch_rdy", S_FETCH);
        bus.mem_ready = 1'b0;
        step("lw_decode", S_DECODE);
        bus.mem_ready = 1'b1;
        step("lw_memadr_ignore_rdy", S_MEMADR);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_read_wait", S_MEMREAD);
        bus.mem_ready = 1'b1;
        step("lw_read_rdy", S_MEMREAD);
        step("lw_memwb", S_MEMWB);

        // sw with two wait cycles
        bus.op = OP_STORE;
        step("sw_fetch", S_FETCH);
        step("sw_decode", S_DECODE);
        step("sw_memadr", S_MEMADR);
        bus.mem_ready = 1'b0;
        step("sw_wait0", S_MEMWRITE);
        step("sw_wait1", S_MEMWRITE);
        bus.mem_ready = 1'b1;
        step("sw_done", S_MEMWRITE);

        // I-type
        bus.op = OP_ITYPE;
        step("i_fetch", S_FETCH);
        step("i_decode", S_DECODE);
        step("i_exec", S_EXECI);
        step("i_aluwb", S_ALUWB);

        // branches: beq taken, bne not taken, bne taken, unsupported funct3 never taken
        bus.op = OP_BRANCH;
        bus.funct3 = 3'b000; bus.zero = 1'b1;
        step("beq_fetch", S_FETCH);
        step("beq_decode", S_DECODE);
        step("beq_branch", S_BRANCH);
        bus.funct3 = 3'b001; bus.zero = 1'b1;
        step("bne_fetch", S_FETCH);
        step("bne_decode", S_DECODE);
        step("bne_z1_branch", S_BRANCH);
        bus.zero = 1'b0;
        step("bne2_fetch", S_FETCH);
        step("bne2_decode", S_DECODE);
        step("bne_z0_branch", S_BRANCH);
        bus.funct3 = 3'b100; bus.zero = 1'b1;
        step("blt_fetch", S_FETCH);
        step("blt_decode", S_DECODE);
        step("f3_100_branch", S_BRANCH);
        bus.funct3 = 3'b000; bus.zero = 1'b0;

        // jal
        bus.op = OP_JAL;
        step("jal_fetch", S_FETCH);
        step("jal_decode", S_DECODE);
        step("jal_jal", S_JAL);
        step("jal_aluwb", S_ALUWB);

        // reset during a pending store: outputs drop in the same cycle
        bus.op = OP_STORE;
        step("abort_fetch", S_FETCH);
        step("abort_decode", S_DECODE);
        step("abort_memadr", S_MEMADR);
        bus.mem_ready = 1'b0;
        step("abort_wait", S_MEMWRITE);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        step("abort_rst", S_FETCH);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        step("abort_refetch", S_FETCH);

        // unsupported opcode parks in HALT regardless of mem_ready
        bus.op = OP_BAD;
        bus.mem_ready = 1'b1;
        step("bad_fetch", S_FETCH);
        step("bad_decode", S_DECODE);
        for (int i = 0; i < 22; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            step("halt_hold", S_HALT);
        end
        rst = 1'b1;
        step("halt_rst", S_FETCH);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        step("halt_refetch", S_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
